// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/acknowledge data bus between the load/store unit and memory.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I memory-stage load/store unit; stalls the pipe across a req/ack bus
// transaction, aligns and extends loads, builds byte enables and lane-replicated store data.
module mem_access_unit #(
    parameter int MAX_WAIT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [2:0]         i_funct3,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_store_data,
    output logic               o_stall,
    output logic [31:0]        o_memory_readout,
    output logic               o_fault,
    mem_access_unit_if.master  bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_inc;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, readout_q, readout_d;
    logic [3:0]    be_q, be_d;
    logic          we_q, we_d, fault_q, fault_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    f3_q, f3_d;
    logic          access, bad_f3, misaligned, legal;
    logic [15:0]   lo;
    logic [31:0]   load_val;
    always_comb begin
        access     = i_valid & (i_mem_read | i_mem_write);
        bad_f3     = (i_funct3[1:0] == 2'b11) | (i_funct3[2] & (i_funct3[1] | i_mem_write))
                   | (i_mem_read & i_mem_write);
        misaligned = ((i_funct3[1:0] == 2'b01) & i_addr[0]) | ((i_funct3[1:0] == 2'b10) & (|i_addr[1:0]));
        legal      = access & ~bad_f3 & ~misaligned;
        lo         = 16'(bus.rdata >> {off_q, 3'b000});
        // funct3[2] selects zero-extension for BU/HU
        load_val   = (f3_q[1:0] == 2'b00) ? {{24{~f3_q[2] & lo[7]}}, lo[7:0]}
                   : (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & lo[15]}}, lo}
                   : bus.rdata;
        cnt_inc    = {1'b0, cnt_q} + 1'b1;
    end
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        off_d     = off_q;
        f3_d      = f3_q;
        readout_d = readout_q;
        fault_d   = 1'b0;
        if (state_q == IDLE) begin
            if (legal) begin
                state_d = REQ;
                cnt_d   = '0;
                addr_d  = {i_addr[31:2], 2'b00};
                we_d    = i_mem_write;
                be_d    = !i_mem_write ? 4'b0000
                        : (i_funct3[1:0] == 2'b00) ? 4'b0001 << i_addr[1:0]
                        : (i_funct3[1:0] == 2'b01) ? (i_addr[1] ? 4'b1100 : 4'b0011)
                        : 4'b1111;
                wdata_d = (i_funct3[1:0] == 2'b00) ? {4{i_store_data[7:0]}}
                        : (i_funct3[1:0] == 2'b01) ? {2{i_store_data[15:0]}}
                        : i_store_data;
                off_d   = i_addr[1:0];
                f3_d    = i_funct3;
            end else begin
                fault_d = access;
            end
        end else if (state_q == REQ) begin
            // an ack in the final wait cycle beats the timeout
            if (bus.ack) begin
                state_d   = DONE;
                readout_d = we_q ? readout_q : load_val;
            end else if (cnt_inc == (CW+1)'(MAX_WAIT)) begin
                state_d   = DONE;
                fault_d   = 1'b1;
                readout_d = '0;
            end else begin
                cnt_d = cnt_inc[CW-1:0];
            end
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            off_q     <= '0;
            f3_q      <= '0;
            readout_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            off_q     <= off_d;
            f3_q      <= f3_d;
            readout_q <= readout_d;
            fault_q   <= fault_d;
        end
    end
    assign o_stall          = ((state_q == IDLE) & legal) | (state_q == REQ);
    assign o_memory_readout = readout_q;
    assign o_fault          = fault_q;
    assign bus.req          = (state_q == REQ);
    assign bus.we           = we_q;
    assign bus.addr         = addr_q;
    assign bus.be           = be_q;
    assign bus.wdata        = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus randomized transactions checked against a
// transaction-level reference model of the load/store unit.
module tb_mem_access_unit;
    localparam int MW = 4;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_store_data = '0;
    logic        o_stall;
    logic [31:0] o_memory_readout;
    logic        o_fault;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_readout = '0;

    mem_access_unit_if bus();

    mem_access_unit #(.MAX_WAIT(MW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_funct3(i_funct3), .i_addr(i_addr),
        .i_store_data(i_store_data), .o_stall(o_stall), .o_memory_readout(o_memory_readout),
        .o_fault(o_fault), .bus(bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic legal_of(input logic rd, input logic wr, input int f3, input logic [31:0] a);
        if (rd && wr) return 1'b0;
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b0;
        if (wr && f3 >= 4) return 1'b0;
        if ((f3 == 1 || f3 == 5) && a % 2 != 0) return 1'b0;
        if (f3 == 2 && a % 4 != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_load(input int f3, input int off, input logic [31:0] rd);
        logic [31:0] w;
        w = rd >> (8 * off);
        case (f3)
            0: return ((w & 32'hFF) ^ 32'h80) - 32'h80;
            1: return ((w & 32'hFFFF) ^ 32'h8000) - 32'h8000;
            4: return w & 32'hFF;
            5: return w & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] exp_be(input int f3, input int off);
        return f3 == 0 ? 32'(1 << off) : f3 == 1 ? 32'(3 << off) : 32'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input int f3, input logic [31:0] sd);
        return f3 == 0 ? (sd & 32'hFF) * 32'h01010101
             : f3 == 1 ? (sd & 32'hFFFF) * 32'h00010001 : sd;
    endfunction

    // one pipeline instruction; k = req cycles without ack before the acking one
    task automatic access(input logic rd, input logic wr, input int f3, input logic [31:0] a,
                          input logic [31:0] sd, input int k, input logic [31:0] rdata);
        logic lg;
        logic to;
        int   n;
        int   stalls;
        tick();
        i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_funct3 = 3'(f3);
        i_addr = a; i_store_data = sd;
        bus.ack = 1'($urandom_range(0, 1)); bus.rdata = $urandom;
        #1;
        lg = legal_of(rd, wr, f3, a);
        chk("stall_first", 32'(o_stall), 32'(lg));
        chk("req_first", 32'(bus.req), 0);
        chk("fault_first", 32'(o_fault), 0);
        if (!lg) begin
            tick();
            i_valid = 1'b0; bus.ack = 1'b0;
            #1;
            chk("fault_illegal", 32'(o_fault), 32'(rd | wr));
            chk("req_illegal", 32'(bus.req), 0);
            chk("stall_illegal", 32'(o_stall), 0);
            chk("readout_illegal", o_memory_readout, m_readout);
            return;
        end
        to = (k >= MW);
        n = to ? MW : k + 1;
        stalls = int'(o_stall);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.ack = (i == k);
            bus.rdata = (i == k) ? rdata : $urandom;
            #1;
            chk("req_wait", 32'(bus.req), 1);
            chk("addr", bus.addr, a & 32'hFFFF_FFFC);
            chk("we", 32'(bus.we), 32'(wr));
            chk("be", 32'(bus.be), wr ? exp_be(f3, int'(a % 4)) : 0);
            if (wr) chk("wdata", bus.wdata, exp_wdata(f3, sd));
            chk("fault_wait", 32'(o_fault), 0);
            stalls += int'(o_stall);
        end
        tick();
        bus.ack = 1'($urandom_range(0, 1));
        #1;
        if (to) m_readout = 0;
        else if (rd) m_readout = exp_load(f3, int'(a % 4), rdata);
        chk("stall_done", 32'(o_stall), 0);
        chk("req_done", 32'(bus.req), 0);
        chk("fault_done", 32'(o_fault), 32'(to));
        chk("stall_cycles", 32'(stalls), 32'(n + 1));
        chk("readout", o_memory_readout, m_readout);
    endtask

    task automatic idle();
        tick();
        i_valid = 1'($urandom_range(0, 1)); i_mem_read = 1'b0; i_mem_write = 1'b0;
        if (!i_valid) begin i_mem_read = 1'($urandom_range(0, 1)); i_mem_write = 1'($urandom_range(0, 1)); end
        bus.ack = 1'($urandom_range(0, 1));
        #1;
        chk("idle_stall", 32'(o_stall), 0);
        chk("idle_req", 32'(bus.req), 0);
        chk("idle_fault", 32'(o_fault), 0);
        chk("idle_readout", o_memory_readout, m_readout);
    endtask

    initial begin
        bus.ack = 1'b0;
        bus.rdata = '0;
        tick();
        tick();
        chk("rst_stall", 32'(o_stall), 0);
        chk("rst_req", 32'(bus.req), 0);
        chk("rst_we", 32'(bus.we), 0);
        chk("rst_be", 32'(bus.be), 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_readout", o_memory_readout, 0);
        chk("rst_fault", 32'(o_fault), 0);
        i_rst_n = 1'b1;
        access(1, 0, 2, 32'h100, 0, 2, 32'h8000_00F0);
        access(1, 0, 0, 32'h103, 0, 0, 32'h8000_0000);
        chk("lb_value", o_memory_readout, 32'hFFFF_FF80);
        access(1, 0, 4, 32'h103, 0, 0, 32'h8000_0000);
        chk("lbu_value", o_memory_readout, 32'h0000_0080);
        access(1, 0, 5, 32'h102, 0, 0, 32'h8000_0000);
        chk("lhu_value", o_memory_readout, 32'h0000_8000);
        access(0, 1, 0, 32'h201, 32'h1234_56AB, 0, 0);
        access(0, 1, 1, 32'h202, 32'h1234_56AB, 1, 0);
        chk("store_keeps_readout", o_memory_readout, 32'h0000_8000);
        access(1, 0, 2, 32'h102, 0, 0, 0);
        access(0, 1, 1, 32'h011, 32'h5555_AAAA, 0, 0);
        access(1, 1, 2, 32'h300, 0, 0, 0);
        access(1, 0, 3, 32'h300, 0, 0, 0);
        access(1, 0, 2, 32'h400, 0, MW, 32'hDEAD_BEEF);
        access(1, 0, 2, 32'h404, 0, MW - 1, 32'hCAFE_F00D);
        access(1, 0, 1, 32'h40A, 0, 1, 32'h9876_5432);
        idle();
        // reset while a request is outstanding, then a stray late ack
        tick();
        i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_funct3 = 3'd2;
        i_addr = 32'h40; bus.ack = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(o_stall), 1);
        tick();
        chk("rst_mid_req", 32'(bus.req), 1);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1; i_valid = 1'b0; bus.ack = 1'b1; bus.rdata = 32'h1111_2222;
        m_readout = 0;
        #1;
        chk("rst_mid_req_drop", 32'(bus.req), 0);
        chk("rst_mid_fault", 32'(o_fault), 0);
        chk("rst_mid_stall_drop", 32'(o_stall), 0);
        chk("rst_mid_readout", o_memory_readout, 0);
        tick();
        chk("late_ack_req", 32'(bus.req), 0);
        chk("late_ack_fault", 32'(o_fault), 0);
        chk("late_ack_readout", o_memory_readout, m_readout);
        bus.ack = 1'b0;
        for (int t = 0; t < 300; t++) begin
            logic rd, wr;
            int   f3;
            rd = 1'($urandom_range(0, 1));
            wr = rd ? ($urandom_range(0, 7) == 0) : 1'b1;
            case ($urandom_range(0, 6))
                0: f3 = $urandom_range(0, 7);
                1, 2: f3 = 2;
                3: f3 = 1;
                4: f3 = 0;
                5: f3 = 4;
                default: f3 = 5;
            endcase
            access(rd, wr, f3, $urandom, $urandom, $urandom_range(0, MW + 1), $urandom);
            if ($urandom_range(0, 4) == 0) idle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit for the pipelined RV32I core. It turns the memory-stage instruction into a multi-cycle request/acknowledge transaction on the data bus and stalls the pipeline until the transaction completes. It aligns load data and sign- or zero-extends it into the memory readout consumed by writeback. It also generates byte enables and lane-replicated write data for stores.

## Interface
- MAX_WAIT, 255: cycles a request may stay unacknowledged before it is abandoned (1..1023)
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  memory-stage slot holds a real instruction
- i_mem_read  in  1  instruction is a load
- i_mem_write  in  1  instruction is a store
- i_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- i_addr  in  32  byte address (ALU result)
- i_store_data  in  32  rs2 value
- o_stall  out  1  freeze IF..MEM, bubble into WB
- o_memory_readout  out  32  aligned, extended load data
- o_fault  out  1  one-cycle pulse: misaligned, illegal funct3, read+write both set, or timeout
- o_bus_req  out  1  bus request
- o_bus_we  out  1  1 = write
- o_bus_addr  out  32  word address, bits [1:0] = 00
- o_bus_be  out  4  byte enables (all 0 on reads)
- o_bus_wdata  out  32  write data
- i_bus_ack  in  1  request accepted/complete; i_bus_rdata is valid in the same cycle
- i_bus_rdata  in  32  read word

## Operation
- The FSM has three states: IDLE, REQ and DONE.
- An access is `i_valid & (i_mem_read | i_mem_write)`.
- IDLE, legal access:
  - Register the bus fields: address `{i_addr[31:2],2'b00}`, we, be, wdata, plus `i_addr[1:0]` and i_funct3.
  - Go to REQ.
- IDLE, illegal access:
  - Pulse o_fault, issue no request, keep o_stall at 0, stay in IDLE.
  - Misaligned means H with `addr[0]=1`, or W with `addr[1:0]≠0`.
  - Illegal funct3 means 011/110/111, 100/101 on a store, or read and write both set.
- REQ:
  - o_bus_req=1; all bus fields stay stable.
  - On i_bus_ack: for a load, capture the aligned/extended data into the readout register; go to DONE.
  - A wait counter increments each REQ cycle without ack.
  - When the counter reaches MAX_WAIT: drop the request, pulse o_fault, load readout=0, go to DONE.
  - Counter width is clog2(MAX_WAIT+1). It clears on entry to REQ.
- DONE: o_stall=0 so the pipeline advances past the instruction. Always return to IDLE next cycle. The still-present i_valid is never re-issued.
- Stores:
  - SB: be = `4'b0001 << addr[1:0]`, wdata = `{4{rs2[7:0]}}`.
  - SH: be = addr[1] ? 1100 : 0011, wdata = `{2{rs2[15:0]}}`.
  - SW: be = 1111, wdata = rs2.
- Loads:
  - Shift the word by `8*addr[1:0]`.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW is passed through.
- o_memory_readout holds its value until the next load completes. Stores do not change it.
- o_stall = (IDLE & legal access) | REQ. It is combinational.

## Timing
- Reset values: state IDLE, counter 0, o_bus_req 0, o_bus_we 0, o_bus_be 0, o_bus_addr 0, o_bus_wdata 0, o_memory_readout 0, o_fault 0, o_stall 0.
- Reset mid-transaction: o_bus_req is 0 from the next edge. The pending ack is ignored and no fault is raised.
- Access arrives in cycle T (stall=1) → o_bus_req=1 from T+1.
  - With ack at T+1+k, DONE is at T+2+k, o_stall=0 in that cycle, and o_bus_req=0 from T+2+k.
  - The minimum is 2 stall cycles (k=0).
- The bus holds o_bus_* constant while req=1 and not acked. i_bus_ack while req=0 is ignored.
- The timeout fires on the cycle the counter equals MAX_WAIT with no ack. If ack arrives in that same cycle, ack wins and there is no fault.
- o_fault is registered: it is high for exactly one cycle, T+1 after a detected illegal access, or the DONE cycle for a timeout.
- Back-to-back accesses: the second is seen in the cycle after DONE, with no lost cycle beyond that.

## Test plan
- LW at 0x100, rdata 0x8000_00F0, ack 3 cycles after req → bus addr 0x100, be 0000, stall high for 4 cycles, readout 0x8000_00F0.
- LB at 0x103, rdata 0x8000_0000, ack 0 wait → readout 0xFFFF_FF80. LBU same → 0x0000_0080. LHU at 0x102 → 0x0000_8000.
- SB at 0x201, rs2 0x1234_56AB → addr 0x200, we 1, be 0010, wdata 0xABAB_ABAB. SH at 0x202 → be 1100, wdata 0x56AB_56AB. Readout is unchanged after both.
- LW at 0x102 and SH at 0x011 → o_fault one-cycle pulse each, o_bus_req never rises, stall stays 0.
- MAX_WAIT=4, no ack → req high exactly 4 cycles, then fault pulse, readout 0, stall released. Repeat with ack on the 4th cycle → no fault, data captured.
- i_rst_n low for one cycle during REQ → req 0 next cycle, state IDLE, no fault. A late ack afterwards has no effect.
